// File: rtl/bucket_dispatch.sv
// Per-bucket FIFOs after the address hash, drained round-robin; drains all queues before acking a coefficient refresh.
// Define BUCKET_STATS_EN to add saturating per-bucket push counters on stat_count.
module bucket_dispatch #(
  parameter int ADDR_WIDTH     = 64,
  parameter int LG_NUM_BUCKETS = 2,
  parameter int LG_FIFO_DEPTH  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [ADDR_WIDTH-1:0]     in_addr,
  input  logic [LG_NUM_BUCKETS-1:0] in_bucket,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_addr,
  output logic [LG_NUM_BUCKETS-1:0] out_bucket,
  input  logic                      refresh_req,
  output logic                      refresh_ack,
`ifdef BUCKET_STATS_EN
  output logic [(2**LG_NUM_BUCKETS)*16-1:0] stat_count,
`endif
  output logic                      busy
);

  localparam int NUM_BUCKETS = 2**LG_NUM_BUCKETS;
  localparam int DEPTH       = 2**LG_FIFO_DEPTH;
  localparam int PW          = LG_FIFO_DEPTH + 1;

  typedef enum logic [1:0] {RUN, DRAIN, ACK} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_WIDTH-1:0]       mem_q [NUM_BUCKETS][DEPTH];
  logic [ADDR_WIDTH-1:0]       mem_d [NUM_BUCKETS][DEPTH];
  logic [PW-1:0]               wr_ptr_q [NUM_BUCKETS];
  logic [PW-1:0]               wr_ptr_d [NUM_BUCKETS];
  logic [PW-1:0]               rd_ptr_q [NUM_BUCKETS];
  logic [PW-1:0]               rd_ptr_d [NUM_BUCKETS];
  logic [LG_NUM_BUCKETS-1:0]   rr_ptr_q, rr_ptr_d;
  logic                        lock_q, lock_d;
  logic [LG_NUM_BUCKETS-1:0]   lock_sel_q, lock_sel_d;
  logic [NUM_BUCKETS-1:0]      empty, full;
  logic [LG_NUM_BUCKETS-1:0]   sel, idx;
  logic                        found, push, pop, all_empty_d;
`ifdef BUCKET_STATS_EN
  logic [15:0]                 stat_q [NUM_BUCKETS];
  logic [15:0]                 stat_d [NUM_BUCKETS];
`endif

  always_comb begin
    empty = '0;
    full  = '0;
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      full[i]  = (wr_ptr_q[i][PW-1] != rd_ptr_q[i][PW-1]) &&
                 (wr_ptr_q[i][PW-2:0] == rd_ptr_q[i][PW-2:0]);
    end
  end

  // A stalled head stays locked so a newly filled higher-priority bucket cannot swap the presented entry.
  always_comb begin
    sel   = '0;
    idx   = '0;
    found = 1'b0;
    if (lock_q) begin
      sel   = lock_sel_q;
      found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_BUCKETS; k++) begin
        idx = rr_ptr_q + LG_NUM_BUCKETS'(k);
        if (!found && !empty[idx]) begin
          sel   = idx;
          found = 1'b1;
        end
      end
    end
    out_valid  = found;
    out_addr   = found ? mem_q[sel][rd_ptr_q[sel][PW-2:0]] : '0;
    out_bucket = found ? sel : '0;
  end

  always_comb begin
    push        = in_valid && in_ready;
    pop         = out_valid && out_ready;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    rr_ptr_d    = rr_ptr_q;
    lock_d      = out_valid && !out_ready;
    lock_sel_d  = sel;
    all_empty_d = 1'b1;
    if (push) begin
      mem_d[in_bucket][wr_ptr_q[in_bucket][PW-2:0]] = in_addr;
      wr_ptr_d[in_bucket] = wr_ptr_q[in_bucket] + PW'(1);
    end
    if (pop) begin
      rd_ptr_d[sel] = rd_ptr_q[sel] + PW'(1);
      rr_ptr_d      = sel + LG_NUM_BUCKETS'(1);
    end
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      if (wr_ptr_d[i] != rd_ptr_d[i]) all_empty_d = 1'b0;
    end
  end

`ifdef BUCKET_STATS_EN
  // Counts restart after every refresh since the bucket mapping changes.
  always_comb begin
    stat_d     = stat_q;
    stat_count = '0;
    for (int i = 0; i < NUM_BUCKETS; i++) begin
      if (state_q == ACK) stat_d[i] = '0;
      else if (push && (in_bucket == LG_NUM_BUCKETS'(i)) && (stat_q[i] != 16'hFFFF))
        stat_d[i] = stat_q[i] + 16'd1;
      stat_count[16*i +: 16] = stat_q[i];
    end
  end
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      RUN:     if (refresh_req) state_d = DRAIN;
      DRAIN:   if (all_empty_d) state_d = ACK;
      ACK:     state_d = RUN;
      default: state_d = RUN;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == RUN) && !full[in_bucket];
    refresh_ack = (state_q == ACK);
    busy        = (state_q != RUN) || !(&empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= RUN;
      rr_ptr_q   <= '0;
      lock_q     <= 1'b0;
      lock_sel_q <= '0;
      for (int i = 0; i < NUM_BUCKETS; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
`ifdef BUCKET_STATS_EN
        stat_q[i]   <= '0;
`endif
        for (int j = 0; j < DEPTH; j++) mem_q[i][j] <= '0;
      end
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      lock_q     <= lock_d;
      lock_sel_q <= lock_sel_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_q      <= mem_d;
`ifdef BUCKET_STATS_EN
      stat_q     <= stat_d;
`endif
    end
  end

endmodule
